// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with registered branch/jump redirect (PCSrc/PCTarget), 1-cycle latency.
// Stall holds every output; Flush (or an invalid EX slot) loads an all-zero bubble.
module ex_mem_pipe_reg #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Stall,
    input  logic          Flush,
    input  logic          Valid_in,
    input  logic          RegWrite_in,
    input  logic          MemRead_in,
    input  logic          MemWrite_in,
    input  logic          MemToReg_in,
    input  logic          Branch_in,
    input  logic          BranchNE_in,
    input  logic          Jump_in,
    input  logic          Zero_in,
    input  logic [DW-1:0] ALUResult_in,
    input  logic [DW-1:0] StoreData_in,
    input  logic [DW-1:0] PC_Plus_Branch_in,
    input  logic [DW-1:0] PCPlusFour_in,
    input  logic [27:0]   j_sll_two_in,
    input  logic [RW-1:0] RegDest_in,
    output logic          Valid_out,
    output logic          RegWrite_out,
    output logic          MemRead_out,
    output logic          MemWrite_out,
    output logic          MemToReg_out,
    output logic [DW-1:0] ALUResult_out,
    output logic [DW-1:0] StoreData_out,
    output logic [RW-1:0] RegDest_out,
    output logic          PCSrc,
    output logic [DW-1:0] PCTarget
);

    typedef struct packed {
        logic          valid;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic [DW-1:0] alu_result;
        logic [DW-1:0] store_data;
        logic [RW-1:0] reg_dest;
        logic          pc_src;
        logic [DW-1:0] pc_target;
    } stage_t;

    stage_t stage_q;
    stage_t load_d;
    logic   taken;

    assign taken = (Branch_in & Zero_in) | (BranchNE_in & ~Zero_in);

    // An invalid EX slot loads the same all-zero bubble as a flush.
    always_comb begin
        load_d = '0;
        if (Valid_in) begin
            load_d.valid      = 1'b1;
            load_d.reg_write  = RegWrite_in;
            load_d.mem_read   = MemRead_in;
            load_d.mem_write  = MemWrite_in;
            load_d.mem_to_reg = MemToReg_in;
            load_d.alu_result = ALUResult_in;
            load_d.store_data = StoreData_in;
            load_d.reg_dest   = RegDest_in;
            load_d.pc_src     = taken | Jump_in;
            load_d.pc_target  = Jump_in ? {PCPlusFour_in[DW-1:28], j_sll_two_in}
                                        : PC_Plus_Branch_in;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stage_q <= '0;
        end else if (Flush) begin
            stage_q <= '0;
        end else if (!Stall) begin
            stage_q <= load_d;
        end
    end

    assign Valid_out     = stage_q.valid;
    assign RegWrite_out  = stage_q.reg_write;
    assign MemRead_out   = stage_q.mem_read;
    assign MemWrite_out  = stage_q.mem_write;
    assign MemToReg_out  = stage_q.mem_to_reg;
    assign ALUResult_out = stage_q.alu_result;
    assign StoreData_out = stage_q.store_data;
    assign RegDest_out   = stage_q.reg_dest;
    assign PCSrc         = stage_q.pc_src;
    assign PCTarget      = stage_q.pc_target;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg: each driven cycle pushes the expected stage contents.
module tb_ex_mem_pipe_reg;

    logic        Clk = 1'b0;
    logic        Reset, Stall, Flush, Valid_in;
    logic        RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in;
    logic        Branch_in, BranchNE_in, Jump_in, Zero_in;
    logic [31:0] ALUResult_in, StoreData_in, PC_Plus_Branch_in, PCPlusFour_in;
    logic [27:0] j_sll_two_in;
    logic [4:0]  RegDest_in;
    logic        Valid_out, RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out;
    logic [31:0] ALUResult_out, StoreData_out, PCTarget;
    logic [4:0]  RegDest_out;
    logic        PCSrc;

    typedef struct packed {
        logic        valid, rw, mr, mw, m2r, pcsrc;
        logic [31:0] alu, sd, tgt;
        logic [4:0]  rd;
    } obs_t;

    obs_t model_q = '0;
    obs_t sb[$];
    obs_t exp_o, act_o;
    int   checks = 0;
    int   failures = 0;

    always #5 Clk = ~Clk;

    ex_mem_pipe_reg #(.DW(32), .RW(5)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .Valid_in(Valid_in),
        .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemToReg_in(MemToReg_in), .Branch_in(Branch_in), .BranchNE_in(BranchNE_in),
        .Jump_in(Jump_in), .Zero_in(Zero_in), .ALUResult_in(ALUResult_in),
        .StoreData_in(StoreData_in), .PC_Plus_Branch_in(PC_Plus_Branch_in),
        .PCPlusFour_in(PCPlusFour_in), .j_sll_two_in(j_sll_two_in), .RegDest_in(RegDest_in),
        .Valid_out(Valid_out), .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .MemToReg_out(MemToReg_out),
        .ALUResult_out(ALUResult_out), .StoreData_out(StoreData_out),
        .RegDest_out(RegDest_out), .PCSrc(PCSrc), .PCTarget(PCTarget)
    );

    function automatic obs_t actual();
        obs_t a;
        a.valid = Valid_out;    a.rw  = RegWrite_out;  a.mr = MemRead_out;
        a.mw    = MemWrite_out; a.m2r = MemToReg_out;  a.pcsrc = PCSrc;
        a.alu   = ALUResult_out; a.sd = StoreData_out; a.tgt = PCTarget;
        a.rd    = RegDest_out;
        return a;
    endfunction

    task automatic rand_inputs();
        Valid_in = 1'($urandom);       RegWrite_in = 1'($urandom);
        MemRead_in = 1'($urandom);     MemWrite_in = 1'($urandom);
        MemToReg_in = 1'($urandom);    Branch_in = 1'($urandom);
        BranchNE_in = 1'($urandom);    Jump_in = 1'($urandom);
        Zero_in = 1'($urandom);        ALUResult_in = $urandom;
        StoreData_in = $urandom;       PC_Plus_Branch_in = $urandom;
        PCPlusFour_in = $urandom;      j_sll_two_in = 28'($urandom);
        RegDest_in = 5'($urandom);
    endtask

    task automatic clear_inputs();
        Reset = 0; Stall = 0; Flush = 0; Valid_in = 0;
        RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0; MemToReg_in = 0;
        Branch_in = 0; BranchNE_in = 0; Jump_in = 0; Zero_in = 0;
        ALUResult_in = 0; StoreData_in = 0; PC_Plus_Branch_in = 0; PCPlusFour_in = 0;
        j_sll_two_in = 0; RegDest_in = 0;
    endtask

    // Expected next stage contents from the current inputs, pushed before the edge.
    task automatic step();
        obs_t n;
        logic tk;
        if (Reset || Flush) n = '0;
        else if (Stall) n = model_q;
        else if (!Valid_in) n = '0;
        else begin
            tk = (Branch_in && Zero_in) || (BranchNE_in && !Zero_in);
            n.valid = 1'b1; n.rw = RegWrite_in; n.mr = MemRead_in; n.mw = MemWrite_in;
            n.m2r = MemToReg_in; n.alu = ALUResult_in; n.sd = StoreData_in; n.rd = RegDest_in;
            n.pcsrc = tk || Jump_in;
            n.tgt = Jump_in ? {PCPlusFour_in[31:28], j_sll_two_in} : PC_Plus_Branch_in;
        end
        model_q = n;
        sb.push_back(n);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            Reset = 1; Stall = 1'($urandom); Flush = 1'($urandom);
            step();
            exp_o = sb.pop_front(); act_o = actual(); checks++;
            if (act_o !== exp_o) begin
                failures++; $display("FAIL reset_sb act=%h exp=%h", act_o, exp_o);
            end
            checks++;
            if (act_o !== '0 || Valid_out !== 1'b0 || PCSrc !== 1'b0) begin
                failures++; $display("FAIL reset_zero act=%h exp=0", act_o);
            end
        end
    endtask

    task automatic test_branch();
        clear_inputs();
        Valid_in = 1; Branch_in = 1; Zero_in = 1;
        PC_Plus_Branch_in = 32'h0040_0020; PCPlusFour_in = 32'h0040_0004;
        step();
        exp_o = sb.pop_front(); act_o = actual(); checks++;
        if (act_o !== exp_o) begin
            failures++; $display("FAIL beq_taken_sb act=%h exp=%h", act_o, exp_o);
        end
        checks++;
        if (PCSrc !== 1'b1 || PCTarget !== 32'h0040_0020) begin
            failures++; $display("FAIL beq_taken pcsrc=%b tgt=%h exp 1/00400020", PCSrc, PCTarget);
        end
        Zero_in = 0;
        step();
        exp_o = sb.pop_front(); act_o = actual(); checks++;
        if (act_o !== exp_o || PCSrc !== 1'b0) begin
            failures++; $display("FAIL beq_not_taken act=%h exp=%h", act_o, exp_o);
        end
        Branch_in = 0; BranchNE_in = 1; Zero_in = 0; PC_Plus_Branch_in = 32'h0040_0100;
        step();
        exp_o = sb.pop_front(); act_o = actual(); checks++;
        if (act_o !== exp_o || PCSrc !== 1'b1 || PCTarget !== 32'h0040_0100) begin
            failures++; $display("FAIL bne_taken act=%h exp=%h", act_o, exp_o);
        end
    endtask

    task automatic test_jump();
        clear_inputs();
        Valid_in = 1; Jump_in = 1; PCPlusFour_in = 32'h1000_0008; j_sll_two_in = 28'h000_0100;
        PC_Plus_Branch_in = 32'h0BAD_0000;
        step();
        exp_o = sb.pop_front(); act_o = actual(); checks++;
        if (act_o !== exp_o || PCSrc !== 1'b1 || PCTarget !== 32'h1000_0100) begin
            failures++; $display("FAIL jump pcsrc=%b tgt=%h exp 1/10000100", PCSrc, PCTarget);
        end
        // jump with an untaken branch still redirects to the jump target
        Branch_in = 1; Zero_in = 0; PCPlusFour_in = 32'hA000_0010; j_sll_two_in = 28'h0ABC_DEF0;
        step();
        exp_o = sb.pop_front(); act_o = actual(); checks++;
        if (act_o !== exp_o || PCSrc !== 1'b1 || PCTarget !== 32'hAABC_DEF0) begin
            failures++; $display("FAIL jump_branch pcsrc=%b tgt=%h exp 1/aabcdef0", PCSrc, PCTarget);
        end
    endtask

    task automatic test_stall();
        clear_inputs();
        Valid_in = 1; MemWrite_in = 1; ALUResult_in = 32'h40; StoreData_in = 32'hDEAD_BEEF;
        RegDest_in = 5'd9;
        step();
        exp_o = sb.pop_front(); act_o = actual(); checks++;
        if (act_o !== exp_o) begin
            failures++; $display("FAIL sw_capture act=%h exp=%h", act_o, exp_o);
        end
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            Reset = 0; Flush = 0; Stall = 1;
            step();
            exp_o = sb.pop_front(); act_o = actual(); checks++;
            if (act_o !== exp_o || ALUResult_out !== 32'h40 || StoreData_out !== 32'hDEAD_BEEF
                || MemWrite_out !== 1'b1 || Valid_out !== 1'b1) begin
                failures++; $display("FAIL stall_hold cyc=%0d act=%h exp=%h", i, act_o, exp_o);
            end
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        Valid_in = 1; RegWrite_in = 1; Jump_in = 1; ALUResult_in = 32'h1234; j_sll_two_in = 28'h40;
        step();
        void'(sb.pop_front());
        Stall = 1; Flush = 1; Jump_in = 0; MemRead_in = 1; MemToReg_in = 1; ALUResult_in = 32'h88;
        step();
        exp_o = sb.pop_front(); act_o = actual(); checks++;
        if (act_o !== exp_o || Valid_out !== 0 || MemRead_out !== 0 || RegWrite_out !== 0
            || ALUResult_out !== 0 || PCSrc !== 0 || PCTarget !== 0) begin
            failures++; $display("FAIL stall_flush act=%h exp=%h", act_o, exp_o);
        end
    endtask

    task automatic test_invalid();
        clear_inputs();
        Valid_in = 0; RegWrite_in = 1; MemWrite_in = 1; Branch_in = 1; Zero_in = 1;
        Jump_in = 1; ALUResult_in = 32'hFFFF; PC_Plus_Branch_in = 32'h44;
        step();
        exp_o = sb.pop_front(); act_o = actual(); checks++;
        if (act_o !== exp_o || RegWrite_out !== 0 || MemWrite_out !== 0 || PCSrc !== 0) begin
            failures++; $display("FAIL invalid_bubble act=%h exp=%h", act_o, exp_o);
        end
        // illegal read+write pair is passed through untouched
        Valid_in = 1; MemRead_in = 1; Jump_in = 0; Branch_in = 0;
        step();
        exp_o = sb.pop_front(); act_o = actual(); checks++;
        if (act_o !== exp_o || MemRead_out !== 1 || MemWrite_out !== 1) begin
            failures++; $display("FAIL rd_wr_pair act=%h exp=%h", act_o, exp_o);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            rand_inputs();
            Reset = ($urandom_range(0, 15) == 0);
            Flush = ($urandom_range(0, 5) == 0);
            Stall = ($urandom_range(0, 3) == 0);
            step();
        end
        clear_inputs();
        while (sb.size() > 0) begin
            exp_o = sb.pop_front();
            if (sb.size() == 0) begin
                act_o = actual(); checks++;
                if (act_o !== exp_o) begin
                    failures++; $display("FAIL back_to_back_last act=%h exp=%h", act_o, exp_o);
                end
            end
        end
    endtask

    // Random traffic checked cycle by cycle (the batch task above only checks the final state).
    task automatic test_random_cycle();
        for (int i = 0; i < 60; i++) begin
            rand_inputs();
            Reset = ($urandom_range(0, 15) == 0);
            Flush = ($urandom_range(0, 5) == 0);
            Stall = ($urandom_range(0, 3) == 0);
            step();
            exp_o = sb.pop_front(); act_o = actual(); checks++;
            if (act_o !== exp_o) begin
                failures++; $display("FAIL random_cyc%0d act=%h exp=%h", i, act_o, exp_o);
            end
        end
        // reset during stall and flush clears everything
        rand_inputs(); Reset = 1; Stall = 1; Flush = 1;
        step();
        exp_o = sb.pop_front(); act_o = actual(); checks++;
        if (act_o !== exp_o || act_o !== '0) begin
            failures++; $display("FAIL reset_mid_stall act=%h exp=0", act_o);
        end
    endtask

    initial begin
        clear_inputs();
        Reset = 1;
        @(posedge Clk);
        #1;
        test_reset();
        test_branch();
        test_jump();
        test_stall();
        test_flush();
        test_invalid();
        test_back_to_back();
        test_random_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
